// File: rtl/unified_mem_pkg.sv
// rtl/unified_mem_pkg.sv - shared constants and port-to-bank mapping for unified_mem
package unified_mem_pkg;

   localparam int BYTE_W = 8;
   localparam int NBANKS = 3;
   localparam int NPORTS = 6;

   // Ports p and p+NBANKS share a bank; the lower one is side A, the upper side B.
   function automatic int port_to_bank(input int p);
      return p % NBANKS;
   endfunction

   function automatic int port_to_side(input int p);
      return p / NBANKS;
   endfunction

endpackage

// File: rtl/unified_mem_bank.sv
// rtl/unified_mem_bank.sv - one RAMSIZE x 8 dual-port bank, async clear, combinational reads
module unified_mem_bank
   import unified_mem_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int RAMSIZE = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_a,
   input  logic [WIDTH-1:0]  addr_a,
   input  logic [BYTE_W-1:0] wd_a,
   output logic [BYTE_W-1:0] rd_a,
   input  logic              we_b,
   input  logic [WIDTH-1:0]  addr_b,
   input  logic [BYTE_W-1:0] wd_b,
   output logic [BYTE_W-1:0] rd_b
);

   localparam int             AW    = (RAMSIZE > 1) ? $clog2(RAMSIZE) : 1;
   localparam logic [WIDTH-1:0] DEPTH = WIDTH'(RAMSIZE);

   logic [BYTE_W-1:0] mem_q [RAMSIZE];
   logic [BYTE_W-1:0] mem_d [RAMSIZE];

   logic          hit_a;
   logic          hit_b;
   logic [AW-1:0] idx_a;
   logic [AW-1:0] idx_b;

   // Full-width unsigned compare, so rebased underflow addresses fall out of range.
   assign hit_a = (addr_a < DEPTH);
   assign hit_b = (addr_b < DEPTH);
   assign idx_a = addr_a[AW-1:0];
   assign idx_b = addr_b[AW-1:0];

   always_comb begin
      mem_d = mem_q;
      if (we_a && hit_a) begin
         mem_d[idx_a] = wd_a;
      end
      // Applied after A so that B wins a same-address collision.
      if (we_b && hit_b) begin
         mem_d[idx_b] = wd_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RAMSIZE; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_a = hit_a ? mem_q[idx_a] : '0;
   assign rd_b = hit_b ? mem_q[idx_b] : '0;

endmodule

// File: rtl/unified_mem.sv
// rtl/unified_mem.sv - three-bank six-port byte memory for fetch (ports 0..2) and data (ports 3..5)
module unified_mem
   import unified_mem_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int RAMSIZE = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NPORTS-1:0]        we,
   input  logic [WIDTH*NPORTS-1:0]  a,
   input  logic [WIDTH*NPORTS-1:0]  wd,
   output logic [BYTE_W*NPORTS-1:0] rd
);

   logic              bank_we   [NBANKS][2];
   logic [WIDTH-1:0]  bank_addr [NBANKS][2];
   logic [BYTE_W-1:0] bank_wd   [NBANKS][2];
   logic [BYTE_W-1:0] bank_rd   [NBANKS][2];

   // Only the low byte of each write-data field is stored.
   logic [NPORTS-1:0] unused_wd_hi;

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      localparam int B = port_to_bank(p);
      localparam int S = port_to_side(p);

      assign bank_we[B][S]   = we[p];
      assign bank_addr[B][S] = a[WIDTH*p +: WIDTH];
      assign bank_wd[B][S]   = wd[WIDTH*p +: BYTE_W];
      assign rd[BYTE_W*p +: BYTE_W] = bank_rd[B][S];
      assign unused_wd_hi[p] = ^wd[WIDTH*p+BYTE_W +: WIDTH-BYTE_W];
   end

   for (genvar k = 0; k < NBANKS; k++) begin : g_bank
      unified_mem_bank #(
         .WIDTH   (WIDTH),
         .RAMSIZE (RAMSIZE)
      ) u_bank (
         .clk    (clk),
         .rst_n  (rst_n),
         .we_a   (bank_we[k][0]),
         .addr_a (bank_addr[k][0]),
         .wd_a   (bank_wd[k][0]),
         .rd_a   (bank_rd[k][0]),
         .we_b   (bank_we[k][1]),
         .addr_b (bank_addr[k][1]),
         .wd_b   (bank_wd[k][1]),
         .rd_b   (bank_rd[k][1])
      );
   end

endmodule

// File: tb/tb_unified_mem.sv
// tb/tb_unified_mem.sv - table-driven self-checking bench for unified_mem
module tb_unified_mem;

   logic        clk;
   logic        rst_n;
   logic [5:0]  we;
   logic [95:0] a;
   logic [95:0] wd;
   logic [47:0] rd;

   int checks;
   int failures;

   unified_mem #(.WIDTH(16), .RAMSIZE(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .a     (a),
      .wd    (wd),
      .rd    (rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  we;
      logic [95:0] a;
      logic [95:0] wd;
      logic [47:0] exp;
   } vec_t;

   vec_t vecs [13];

   function automatic logic [95:0] mk_a(input logic [15:0] a0, a1, a2, a3, a4, a5);
      return {a5, a4, a3, a2, a1, a0};
   endfunction

   function automatic logic [95:0] all_a(input logic [15:0] x);
      return {x, x, x, x, x, x};
   endfunction

   function automatic logic [47:0] mk_rd(input logic [7:0] b0, b1, b2, b3, b4, b5);
      return {b5, b4, b3, b2, b1, b0};
   endfunction

   task automatic check_lanes(input logic [47:0] exp, input string name);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (rd[8*i +: 8] !== exp[8*i +: 8]) begin
            failures++;
            $display("FAIL %s lane%0d got=%02h want=%02h", name, i, rd[8*i +: 8], exp[8*i +: 8]);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Each vector: inputs driven on negedge, rd checked before the next posedge, then the edge commits writes.
      vecs[0]  = '{6'b001000, all_a(16'd3), mk_a(0, 0, 0, 16'h12AB, 0, 0), mk_rd(0, 0, 0, 0, 0, 0)};
      vecs[1]  = '{6'b000000, all_a(16'd3), '0, mk_rd(8'hAB, 0, 0, 8'hAB, 0, 0)};
      vecs[2]  = '{6'b111000, all_a(16'd7), mk_a(0, 0, 0, 16'h0011, 16'h0022, 16'h0033), mk_rd(0, 0, 0, 0, 0, 0)};
      vecs[3]  = '{6'b000000, all_a(16'd7), '0, mk_rd(8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33)};
      vecs[4]  = '{6'b010000, mk_a(7, 7, 7, 7, 16'hFFF0, 7), mk_a(0, 0, 0, 0, 16'h0055, 0),
                   mk_rd(8'h11, 8'h22, 8'h33, 8'h11, 8'h00, 8'h33)};
      vecs[5]  = '{6'b000000, mk_a(7, 0, 7, 16, 7, 16), '0, mk_rd(8'h11, 8'h00, 8'h33, 8'h00, 8'h22, 8'h00)};
      vecs[6]  = '{6'b010010, all_a(16'd2), mk_a(0, 16'h00AA, 0, 0, 16'h00BB, 0), mk_rd(0, 0, 0, 0, 0, 0)};
      vecs[7]  = '{6'b000000, all_a(16'd2), '0, mk_rd(0, 8'hBB, 0, 0, 8'hBB, 0)};
      vecs[8]  = '{6'b001000, all_a(16'd9), mk_a(0, 0, 0, 16'h0001, 0, 0), mk_rd(0, 0, 0, 0, 0, 0)};
      vecs[9]  = '{6'b001000, all_a(16'd9), mk_a(0, 0, 0, 16'h0002, 0, 0), mk_rd(8'h01, 0, 0, 8'h01, 0, 0)};
      vecs[10] = '{6'b000000, all_a(16'd9), '0, mk_rd(8'h02, 0, 0, 8'h02, 0, 0)};
      vecs[11] = '{6'b000001, all_a(16'd15), mk_a(16'hFF7E, 0, 0, 0, 0, 0), mk_rd(0, 0, 0, 0, 0, 0)};
      vecs[12] = '{6'b000000, all_a(16'd15), '0, mk_rd(8'h7E, 0, 0, 8'h7E, 0, 0)};

      rst_n = 1'b0;
      we    = '0;
      a     = '0;
      wd    = '0;
      repeat (2) @(negedge clk);
      #1;
      check_lanes(48'h0, "reset_initial");
      rst_n = 1'b1;

      for (int v = 0; v < 13; v++) begin
         @(negedge clk);
         we = vecs[v].we;
         a  = vecs[v].a;
         wd = vecs[v].wd;
         #1;
         check_lanes(vecs[v].exp, $sformatf("vec%0d", v));
      end

      // Contents survive an idle cycle, then an asynchronous mid-cycle reset clears them at once.
      @(negedge clk);
      we = '0;
      a  = all_a(16'd7);
      #1;
      check_lanes(mk_rd(8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33), "pre_reset");
      #1;
      rst_n = 1'b0;
      #1;
      check_lanes(48'h0, "async_reset");

      // A write attempted while held in reset must be ignored.
      @(negedge clk);
      we = 6'b001000;
      a  = all_a(16'd5);
      wd = mk_a(0, 0, 0, 16'h0099, 0, 0);
      @(negedge clk);
      we    = '0;
      rst_n = 1'b1;
      #1;
      check_lanes(48'h0, "reset_addr5");
      a = all_a(16'd3);
      #1;
      check_lanes(48'h0, "reset_addr3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
